// File: rtl/imem_loader.sv
// imem_loader: framed byte-stream loader for the instruction memory.
// Holds the CPU in reset until a length- and checksum-verified image is written.
module imem_loader #(
    parameter int          DEPTH     = 64,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        cpu_hold,
    output logic        done,
    output logic        err,
    output logic [1:0]  err_code,
    output logic [15:0] words_loaded
);

    localparam int IW = $clog2(DEPTH) + 1;

    typedef enum logic [2:0] {
        S_LEN0,
        S_LEN1,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [7:0]      len_lo;
    logic [15:0]     len;
    logic [7:0]      xor_acc;
    logic [IW-1:0]   idx;
    logic [1:0]      bcnt;
    logic [23:0]     sh;
    logic [1:0]      code_q;
    logic            accept;
    logic            rearm;
    logic [15:0]     n_in;
    logic            len_bad;
    logic            last_word;
    logic            csum_ok;

    assign rx_ready     = (state == S_LEN0) || (state == S_LEN1) ||
                          (state == S_DATA) || (state == S_CSUM);
    assign accept       = rx_valid && rx_ready;
    assign n_in         = {rx_data, len_lo};
    assign len_bad      = n_in > 16'(DEPTH);
    assign last_word    = (16'(idx) + 16'd1) == len;
    assign csum_ok      = (xor_acc ^ rx_data) == 8'h00;
    assign err_code     = code_q;
    assign words_loaded = 16'(idx);

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_LEN0;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic and state-decoded status outputs.
    always_comb begin
        state_nx = state;
        cpu_hold = 1'b1;
        done     = 1'b0;
        err      = 1'b0;
        rearm    = 1'b0;
        unique case (state)
            S_LEN0: begin
                if (accept) state_nx = S_LEN1;
            end
            S_LEN1: begin
                if (accept) begin
                    if (len_bad)            state_nx = S_ERR;
                    else if (n_in == 16'd0) state_nx = S_CSUM;
                    else                    state_nx = S_DATA;
                end
            end
            S_DATA: begin
                if (accept && bcnt == 2'd3 && last_word) state_nx = S_CSUM;
            end
            S_CSUM: begin
                if (accept) state_nx = csum_ok ? S_DONE : S_ERR;
            end
            S_DONE: begin
                done     = 1'b1;
                cpu_hold = 1'b0;
                if (start) begin
                    rearm    = 1'b1;
                    state_nx = S_LEN0;
                end
            end
            S_ERR: begin
                err = 1'b1;
                if (start) begin
                    rearm    = 1'b1;
                    state_nx = S_LEN0;
                end
            end
            default: state_nx = S_LEN0;
        endcase
    end

    // Byte assembly, running checksum and the registered imem write port.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            len_lo    <= 8'h00;
            len       <= 16'h0000;
            xor_acc   <= 8'h00;
            idx       <= '0;
            bcnt      <= 2'd0;
            sh        <= 24'h0;
            code_q    <= 2'd0;
            mem_we    <= 1'b0;
            mem_addr  <= BASE_ADDR;
            mem_wdata <= 32'h0;
        end else begin
            mem_we <= 1'b0;
            if (rearm) begin
                idx     <= '0;
                xor_acc <= 8'h00;
                bcnt    <= 2'd0;
                code_q  <= 2'd0;
            end else if (accept) begin
                xor_acc <= xor_acc ^ rx_data;
                unique case (state)
                    S_LEN0: len_lo <= rx_data;
                    S_LEN1: begin
                        len <= n_in;
                        if (len_bad) code_q <= 2'd1;
                    end
                    S_DATA: begin
                        sh   <= {rx_data, sh[23:8]};
                        bcnt <= bcnt + 2'd1;
                        if (bcnt == 2'd3) begin
                            mem_we    <= 1'b1;
                            mem_addr  <= BASE_ADDR + (32'(idx) << 2);
                            mem_wdata <= {rx_data, sh};
                            idx       <= idx + IW'(1);
                        end
                    end
                    S_CSUM: begin
                        if (!csum_ok) code_q <= 2'd2;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
